// File: rtl/psc_trigger_rx.sv
// PSC serial trigger link receiver: recovers frame alignment from the bit stream,
// decodes idle/trigger/corrupt frames and tracks lock and frame-error statistics.
module psc_trigger_rx #(
    parameter int unsigned       WIDTH           = 100,
    parameter logic [WIDTH-1:0]  IDLE_PATTERN    = WIDTH'(100'hC0C0C0C0C0C0C0C0C0C0C0C0C),
    parameter logic [WIDTH-1:0]  TRIGGER_PATTERN = WIDTH'(100'hFF00FF00FF00FF00FF00FF00F),
    parameter int unsigned       LOCK_FRAMES     = 4,
    parameter int unsigned       LOSS_FRAMES     = 3
) (
    input  logic        pll_clock,
    input  logic        reset,
    input  logic        psc_input,
    output logic        trigger_out,
    output logic        locked,
    output logic        frame_error,
    output logic [15:0] frame_errors
);

    localparam int unsigned CNT_W   = $clog2(WIDTH);
    localparam int unsigned MATCH_W = $clog2(LOCK_FRAMES + 1);
    localparam int unsigned BAD_W   = $clog2(LOSS_FRAMES + 1);

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [BAD_W-1:0]   bad_cnt_q, bad_cnt_d;
    logic [1:0]         state_q, state_d;
    logic               trigger_out_q, trigger_out_d;
    logic               frame_error_q, frame_error_d;
    logic               locked_q, locked_d;
    logic [15:0]        frame_errors_q, frame_errors_d;

    logic               is_idle;
    logic               is_trigger;
    logic               boundary;
    logic [MATCH_W-1:0] match_inc;
    logic [BAD_W-1:0]   bad_inc;

    // State and datapath registers
    always_ff @(posedge pll_clock or negedge reset) begin
        if (!reset) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            shreg_q        <= '0;
            frame_cnt_q    <= '0;
            match_cnt_q    <= '0;
            bad_cnt_q      <= '0;
            state_q        <= ST_HUNT;
            trigger_out_q  <= 1'b0;
            frame_error_q  <= 1'b0;
            locked_q       <= 1'b0;
            frame_errors_q <= '0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            shreg_q        <= shreg_d;
            frame_cnt_q    <= frame_cnt_d;
            match_cnt_q    <= match_cnt_d;
            bad_cnt_q      <= bad_cnt_d;
            state_q        <= state_d;
            trigger_out_q  <= trigger_out_d;
            frame_error_q  <= frame_error_d;
            locked_q       <= locked_d;
            frame_errors_q <= frame_errors_d;
        end
    end

    assign is_idle    = (shreg_q == IDLE_PATTERN);
    assign is_trigger = (shreg_q == TRIGGER_PATTERN);
    assign boundary   = (frame_cnt_q == FRAME_LAST);
    assign match_inc  = match_cnt_q + MATCH_W'(1);
    assign bad_inc    = bad_cnt_q + BAD_W'(1);

    // Next-state, frame classification and output decode
    always_comb begin
        sync1_d        = psc_input;
        sync2_d        = sync1_q;
        shreg_d        = {shreg_q[WIDTH-2:0], sync2_q};
        frame_cnt_d    = boundary ? '0 : frame_cnt_q + CNT_W'(1);
        match_cnt_d    = match_cnt_q;
        bad_cnt_d      = bad_cnt_q;
        state_d        = state_q;
        trigger_out_d  = 1'b0;
        frame_error_d  = 1'b0;
        frame_errors_d = frame_errors_q;

        case (state_q)
            ST_HUNT: begin
                if (is_idle) begin
                    frame_cnt_d = '0;
                    match_cnt_d = MATCH_W'(1);
                    state_d     = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (boundary) begin
                    if (is_idle) begin
                        match_cnt_d = match_inc;
                        if (match_inc == MATCH_W'(LOCK_FRAMES)) begin
                            state_d   = ST_LOCKED;
                            bad_cnt_d = '0;
                        end
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
            end
            ST_LOCKED: begin
                if (boundary) begin
                    if (is_idle) begin
                        bad_cnt_d = '0;
                    end else if (is_trigger) begin
                        trigger_out_d = 1'b1;
                        bad_cnt_d     = '0;
                    end else begin
                        frame_error_d = 1'b1;
                        bad_cnt_d     = bad_inc;
                        if (frame_errors_q != 16'hFFFF) begin
                            frame_errors_d = frame_errors_q + 16'd1;
                        end
                        if (bad_inc == BAD_W'(LOSS_FRAMES)) begin
                            state_d = ST_HUNT;
                        end
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase

        locked_d = (state_d == ST_LOCKED);
    end

    assign trigger_out  = trigger_out_q;
    assign frame_error  = frame_error_q;
    assign locked       = locked_q;
    assign frame_errors = frame_errors_q;

endmodule

// File: tb/tb_psc_trigger_rx.sv
// Directed bench for psc_trigger_rx: acquisition, trigger decode, error handling,
// loss of lock, trigger during verification and mid-frame reset.
module tb_psc_trigger_rx;

    logic        pll_clock;
    logic        reset;
    logic        psc_input;
    logic        trigger_out;
    logic        locked;
    logic        frame_error;
    logic [15:0] frame_errors;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int drive_cyc = 0;
    int trig_cnt = 0;
    int err_cnt = 0;
    int both_hi = 0;
    int last_trig_cyc = -1;
    int lock_rise_cyc = -1;
    int lock_fall_cyc = -1;
    logic prev_locked = 1'b0;

    logic [99:0] idle_v;
    logic [99:0] trig_v;
    logic [99:0] bad_v;

    int first_last;
    int t_last;
    int c_last;

    psc_trigger_rx dut (
        .pll_clock    (pll_clock),
        .reset        (reset),
        .psc_input    (psc_input),
        .trigger_out  (trigger_out),
        .locked       (locked),
        .frame_error  (frame_error),
        .frame_errors (frame_errors)
    );

    initial pll_clock = 1'b0;
    always #5 pll_clock = ~pll_clock;

    always @(posedge pll_clock) cyc <= cyc + 1;

    // Pulse and lock-edge monitor, sampled away from the active edge
    always @(negedge pll_clock) begin
        if (trigger_out === 1'b1) begin
            trig_cnt = trig_cnt + 1;
            last_trig_cyc = cyc;
        end
        if (frame_error === 1'b1) err_cnt = err_cnt + 1;
        if (trigger_out === 1'b1 && frame_error === 1'b1) both_hi = both_hi + 1;
        if (locked === 1'b1 && prev_locked === 1'b0) lock_rise_cyc = cyc;
        if (locked === 1'b0 && prev_locked === 1'b1) lock_fall_cyc = cyc;
        prev_locked = locked;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        assert (got === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0d required %0d", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge pll_clock);
        psc_input = b;
        drive_cyc = cyc;
    endtask

    task automatic send_frame(input logic [99:0] p);
        for (int i = 99; i >= 0; i--) send_bit(p[i]);
    endtask

    initial begin
        idle_v = 100'hC0C0C0C0C0C0C0C0C0C0C0C0C;
        trig_v = 100'hFF00FF00FF00FF00FF00FF00F;
        bad_v  = idle_v ^ (100'b1 << 57);
        reset = 1'b0;
        psc_input = 1'b0;
        repeat (3) @(negedge pll_clock);

        chk("rst_trigger_out", 32'(trigger_out), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_frame_error", 32'(frame_error), 32'd0);
        chk("rst_frame_errors", 32'(frame_errors), 32'd0);
        reset = 1'b1;

        // Acquisition from an arbitrary bit phase
        repeat (37) send_bit(1'b0);
        send_frame(idle_v);
        first_last = drive_cyc;
        repeat (3) send_frame(idle_v);
        chk("not_locked_early", 32'(locked), 32'd0);
        send_frame(idle_v);
        chk("acq_locked", 32'(locked), 32'd1);
        chk("acq_lock_time", 32'(lock_rise_cyc), 32'(first_last + 304));
        chk("acq_frame_errors", 32'(frame_errors), 32'd0);
        chk("acq_no_pulses", 32'(trig_cnt + err_cnt), 32'd0);

        // Single trigger frame
        send_frame(trig_v);
        t_last = drive_cyc;
        send_frame(idle_v);
        chk("trig_count", 32'(trig_cnt), 32'd1);
        chk("trig_latency", 32'(last_trig_cyc), 32'(t_last + 4));
        chk("trig_no_error", 32'(err_cnt), 32'd0);
        chk("trig_locked", 32'(locked), 32'd1);

        // One corrupt frame, then a trigger still decodes
        send_frame(bad_v);
        send_frame(idle_v);
        send_frame(trig_v);
        t_last = drive_cyc;
        send_frame(idle_v);
        chk("bad1_err_pulses", 32'(err_cnt), 32'd1);
        chk("bad1_frame_errors", 32'(frame_errors), 32'd1);
        chk("bad1_locked", 32'(locked), 32'd1);
        chk("bad1_trig_count", 32'(trig_cnt), 32'd2);
        chk("bad1_trig_latency", 32'(last_trig_cyc), 32'(t_last + 4));

        // Three consecutive corrupt frames drop lock, then relock
        send_frame(bad_v);
        send_frame(bad_v);
        chk("bad2_still_locked", 32'(locked), 32'd1);
        send_frame(bad_v);
        c_last = drive_cyc;
        send_frame(idle_v);
        first_last = drive_cyc;
        chk("loss_err_pulses", 32'(err_cnt), 32'd4);
        chk("loss_frame_errors", 32'(frame_errors), 32'd4);
        chk("loss_unlocked", 32'(locked), 32'd0);
        chk("loss_fall_time", 32'(lock_fall_cyc), 32'(c_last + 4));
        repeat (3) send_frame(idle_v);
        send_frame(idle_v);
        chk("relock_locked", 32'(locked), 32'd1);
        chk("relock_time", 32'(lock_rise_cyc), 32'(first_last + 304));

        // Trigger frame while verifying: no pulse, acquisition restarts
        repeat (3) send_frame(bad_v);
        send_frame(idle_v);
        send_frame(idle_v);
        send_frame(trig_v);
        send_frame(idle_v);
        first_last = drive_cyc;
        send_frame(idle_v);
        send_frame(idle_v);
        chk("verify_not_locked", 32'(locked), 32'd0);
        send_frame(idle_v);
        send_frame(idle_v);
        chk("verify_trig_count", 32'(trig_cnt), 32'd2);
        chk("verify_locked", 32'(locked), 32'd1);
        chk("verify_lock_time", 32'(lock_rise_cyc), 32'(first_last + 304));
        chk("verify_frame_errors", 32'(frame_errors), 32'd7);
        chk("verify_err_pulses", 32'(err_cnt), 32'd7);

        // One-cycle reset 40 bits into a locked frame
        for (int i = 99; i >= 60; i--) send_bit(idle_v[i]);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_locked", 32'(locked), 32'd0);
        chk("mid_rst_frame_errors", 32'(frame_errors), 32'd0);
        chk("mid_rst_trigger_out", 32'(trigger_out), 32'd0);
        chk("mid_rst_frame_error", 32'(frame_error), 32'd0);
        send_bit(idle_v[59]);
        reset = 1'b1;
        for (int i = 58; i >= 0; i--) send_bit(idle_v[i]);
        send_frame(idle_v);
        first_last = drive_cyc;
        repeat (3) send_frame(idle_v);
        chk("post_rst_not_locked", 32'(locked), 32'd0);
        send_frame(idle_v);
        chk("post_rst_locked", 32'(locked), 32'd1);
        chk("post_rst_lock_time", 32'(lock_rise_cyc), 32'(first_last + 304));
        chk("post_rst_frame_errors", 32'(frame_errors), 32'd0);
        chk("exclusive_pulses", 32'(both_hi), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
